// File: rtl/oled_pixel_streamer.sv
// SSD1331 96x64 OLED frame streamer: sends the address-window prelude, then scans the
// pixel generators in raster order and shifts each RGB565 word out over SPI mode 0.
module oled_pixel_streamer #(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 64,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk25,
    input  logic        rst_n,
    input  logic        enable,
    output logic [12:0] pixel_index,
    input  logic [15:0] color,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    output logic        dc,
    output logic        frame_begin,
    output logic        busy
);

    localparam int NPIX = WIDTH * HEIGHT;
    localparam int PW   = $clog2(2 * CLK_DIV);
    localparam int GW   = $clog2(GAP_CYCLES + 1);

    localparam logic [12:0]   LAST_PIX   = 13'(NPIX - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [PW-1:0] PHASE_HIGH = PW'(CLK_DIV);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

    // Column window 0..WIDTH-1, then row window 0..HEIGHT-1, shifted MSB first.
    localparam logic [47:0] CMD_WORD = {8'h15, 8'h00, 8'(WIDTH - 1),
                                        8'h75, 8'h00, 8'(HEIGHT - 1)};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_PIX,
        S_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [5:0]    bit_cnt_q, bit_cnt_d;
    logic [47:0]   shift_q, shift_d;
    logic [GW-1:0] cnt_q, cnt_d;
    logic [12:0]   pix_q, pix_d;
    logic          cs_n_q, cs_n_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          dc_q, dc_d;
    logic          fb_q, fb_d;
    logic          busy_q, busy_d;

    logic bit_done;
    logic last_bit;

    assign bit_done = (phase_q == PHASE_LAST);
    assign last_bit = bit_done && (bit_cnt_q == 6'd0);

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        pix_d     = pix_q;
        cs_n_d    = cs_n_q;
        sclk_d    = 1'b0;
        mosi_d    = mosi_q;
        dc_d      = dc_q;
        fb_d      = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_IDLE: begin
                cs_n_d = 1'b1;
                dc_d   = 1'b0;
                mosi_d = 1'b0;
                busy_d = 1'b0;
                pix_d  = 13'd0;
                if (enable) begin
                    state_d   = S_CMD;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    fb_d      = 1'b1;
                    shift_d   = CMD_WORD;
                    bit_cnt_d = 6'd47;
                    phase_d   = '0;
                    mosi_d    = CMD_WORD[47];
                end
            end

            S_CMD, S_PIX: begin
                if (last_bit) begin
                    phase_d = '0;
                    cnt_d   = '0;
                    mosi_d  = 1'b0;
                    if (state_q == S_PIX && pix_q == LAST_PIX) begin
                        state_d = S_GAP;
                        cs_n_d  = 1'b1;
                        dc_d    = 1'b0;
                        pix_d   = 13'd0;
                    end else begin
                        state_d = S_FETCH;
                        dc_d    = 1'b1;
                        if (state_q == S_PIX) begin
                            pix_d = pix_q + 13'd1;
                        end
                    end
                end else if (bit_done) begin
                    // Falling edge of sclk: advance to the next bit while sclk returns low.
                    shift_d   = shift_q << 1;
                    bit_cnt_d = bit_cnt_q - 6'd1;
                    phase_d   = '0;
                    mosi_d    = shift_q[46];
                end else begin
                    phase_d = phase_q + 1'b1;
                    sclk_d  = (phase_d >= PHASE_HIGH);
                end
            end

            S_FETCH: begin
                dc_d = 1'b1;
                // color trails pixel_index by one register stage, so it is valid on the second edge.
                if (cnt_q == '0) begin
                    cnt_d = GW'(1);
                end else begin
                    state_d   = S_PIX;
                    shift_d   = {color, 32'd0};
                    bit_cnt_d = 6'd15;
                    phase_d   = '0;
                    mosi_d    = color[15];
                end
            end

            S_GAP: begin
                cs_n_d = 1'b1;
                dc_d   = 1'b0;
                mosi_d = 1'b0;
                pix_d  = 13'd0;
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            bit_cnt_q <= 6'd0;
            shift_q   <= 48'd0;
            cnt_q     <= '0;
            pix_q     <= 13'd0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
            fb_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            pix_q     <= pix_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            dc_q      <= dc_d;
            fb_q      <= fb_d;
            busy_q    <= busy_d;
        end
    end

    assign pixel_index = pix_q;
    assign cs_n        = cs_n_q;
    assign sclk        = sclk_q;
    assign mosi        = mosi_q;
    assign dc          = dc_q;
    assign frame_begin = fb_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Directed bench for oled_pixel_streamer on a reduced 8x4 panel so whole frames fit in a short run.
module tb_oled_pixel_streamer;

    // 8x4 panel, CLK_DIV=2, GAP=16:
    //   prelude   = 48 bits * 4 cycles            = 192
    //   period    = 192 + 32*(2 + 64) + 16 + 1    = 2321
    //   prelude   = 15 00 07 75 00 03
    //   cs_n high = 16 GAP cycles + 1 IDLE cycle   = 17
    localparam int W   = 8;
    localparam int H   = 4;
    localparam int CD  = 2;
    localparam int GAP = 16;

    logic        clk25;
    logic        rst_n;
    logic        enable;
    logic [12:0] pixel_index;
    logic [15:0] color;
    logic        cs_n, sclk, mosi, dc, frame_begin, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int first_fb_cyc;

    logic [7:0]  exp_cmd [6] = '{8'h15, 8'h00, 8'h07, 8'h75, 8'h00, 8'h03};

    // Bus monitor state
    logic [7:0]  cmd_q  [$];
    logic [15:0] word_q [$];
    logic [7:0]  cmd_sr;
    logic [15:0] pix_sr;
    logic [12:0] word_idx;
    int          cmd_bits = 0;
    int          pix_bits = 0;
    int          idx_err = 0;
    int          glitch_err = 0;
    logic        prev_sclk = 1'b0, prev_cs_n = 1'b1, prev_dc = 1'b0, prev_mosi = 1'b0;

    oled_pixel_streamer #(
        .WIDTH(W), .HEIGHT(H), .CLK_DIV(CD), .GAP_CYCLES(GAP)
    ) dut (
        .clk25(clk25), .rst_n(rst_n), .enable(enable), .pixel_index(pixel_index),
        .color(color), .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .dc(dc),
        .frame_begin(frame_begin), .busy(busy)
    );

    initial begin
        clk25 = 1'b0;
        forever #5 clk25 = ~clk25;
    end

    always @(posedge clk25) cyc <= cyc + 1;

    // Pixel generator stub: registered colour equal to the index.
    always @(posedge clk25) color <= {3'b000, pixel_index};

    always @(negedge clk25) begin
        if (!rst_n) begin
            cmd_bits = 0;
            pix_bits = 0;
        end else begin
            if (prev_sclk && sclk && (cs_n !== prev_cs_n || dc !== prev_dc || mosi !== prev_mosi))
                glitch_err++;
            if (sclk && !prev_sclk) begin
                if (!dc) begin
                    cmd_sr = {cmd_sr[6:0], mosi};
                    cmd_bits++;
                    if (cmd_bits == 8) begin
                        cmd_q.push_back(cmd_sr);
                        cmd_bits = 0;
                    end
                end else begin
                    if (pix_bits == 0) word_idx = pixel_index;
                    else if (pixel_index !== word_idx) idx_err++;
                    pix_sr = {pix_sr[14:0], mosi};
                    pix_bits++;
                    if (pix_bits == 16) begin
                        word_q.push_back(pix_sr);
                        pix_bits = 0;
                    end
                end
            end
        end
        prev_sclk = sclk;
        prev_cs_n = cs_n;
        prev_dc   = dc;
        prev_mosi = mosi;
    end

    task automatic tick();
        @(negedge clk25);
        #1;
    endtask

    task automatic test_reset();
        int bad = 0;
        int fb  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({cs_n, sclk, mosi, dc, frame_begin, busy} !== 6'b100000 || pixel_index !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values: cs_n,sclk,mosi,dc,fb,busy=%b idx=%0d, expected 100000 idx=0",
                     {cs_n, sclk, mosi, dc, frame_begin, busy}, pixel_index);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ({cs_n, sclk, mosi, dc, busy} !== 5'b10000 || pixel_index !== 13'd0) bad++;
            if (frame_begin !== 1'b0) fb++;
        end
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_hold: %0d cycles off reset values, expected 0", bad);
        end
        n_tests++;
        if (fb !== 0) begin
            n_fail++;
            $display("FAIL reset_no_frame: %0d frame_begin pulses, expected 0", fb);
        end
    endtask

    task automatic test_cmd_prelude();
        bit found = 0;
        int t0, cs_hi = 0, fb_extra = 0;
        cmd_q.delete();
        word_q.delete();
        glitch_err = 0;
        idx_err    = 0;
        enable     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_begin === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL start_frame_begin: no pulse within 5 cycles, expected 1 cycle after enable");
        end
        t0 = cyc;
        first_fb_cyc = cyc;
        n_tests++;
        if ({cs_n, busy, dc, pixel_index} !== {3'b010, 13'd0}) begin
            n_fail++;
            $display("FAIL start_outputs: cs_n=%b busy=%b dc=%b idx=%0d, expected 0 1 0 0",
                     cs_n, busy, dc, pixel_index);
        end
        found = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (dc === 1'b1) begin
                found = 1;
                break;
            end
            if (cs_n !== 1'b0) cs_hi++;
            if (frame_begin !== 1'b0) fb_extra++;
        end
        n_tests++;
        if (!found || (cyc - t0) !== 192) begin
            n_fail++;
            $display("FAIL prelude_length: %0d cycles (found=%0d), expected 192", cyc - t0, found);
        end
        n_tests++;
        if (cs_hi !== 0 || fb_extra !== 0) begin
            n_fail++;
            $display("FAIL prelude_cs_fb: cs_n high %0d cycles, extra fb %0d, expected 0 0",
                     cs_hi, fb_extra);
        end
        n_tests++;
        if (cmd_q.size() !== 6) begin
            n_fail++;
            $display("FAIL prelude_bytes: %0d bytes, expected 6", cmd_q.size());
        end
        for (int k = 0; k < 6; k++) begin
            logic [7:0] got;
            got = (k < cmd_q.size()) ? cmd_q[k] : 8'hxx;
            n_tests++;
            if (got !== exp_cmd[k]) begin
                n_fail++;
                $display("FAIL prelude_byte%0d: got %h, expected %h", k, got, exp_cmd[k]);
            end
        end
    endtask

    task automatic test_pixel_data();
        bit found = 0;
        int bad = 0;
        logic [15:0] w0, w1, wl;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (cs_n === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL pixel_end: cs_n never rose within 3000 cycles");
        end
        n_tests++;
        if (word_q.size() !== 32) begin
            n_fail++;
            $display("FAIL pixel_count: %0d words, expected 32", word_q.size());
        end
        w0 = (word_q.size() > 0)  ? word_q[0]  : 16'hxxxx;
        w1 = (word_q.size() > 1)  ? word_q[1]  : 16'hxxxx;
        wl = (word_q.size() > 31) ? word_q[31] : 16'hxxxx;
        n_tests++;
        if (w0 !== 16'h0000 || w1 !== 16'h0001) begin
            n_fail++;
            $display("FAIL pixel_first: got %h %h, expected 0000 0001", w0, w1);
        end
        n_tests++;
        if (wl !== 16'h001F) begin
            n_fail++;
            $display("FAIL pixel_last: got %h, expected 001f", wl);
        end
        for (int k = 0; k < word_q.size(); k++)
            if (word_q[k] !== 16'(k)) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL pixel_values: %0d wrong words, expected 0", bad);
        end
        n_tests++;
        if (idx_err !== 0 || glitch_err !== 0) begin
            n_fail++;
            $display("FAIL pixel_stability: index changes %0d, glitches %0d, expected 0 0",
                     idx_err, glitch_err);
        end
        n_tests++;
        if (pixel_index !== 13'd0 || busy !== 1'b1 || dc !== 1'b0 || sclk !== 1'b0) begin
            n_fail++;
            $display("FAIL gap_outputs: idx=%0d busy=%b dc=%b sclk=%b, expected 0 1 0 0",
                     pixel_index, busy, dc, sclk);
        end
    endtask

    task automatic test_frame_timing();
        bit found = 0;
        int hi = 1;
        int bz = (busy === 1'b0) ? 1 : 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (cs_n === 1'b1) begin
                hi++;
                if (busy === 1'b0) bz++;
            end else begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found || hi !== 17) begin
            n_fail++;
            $display("FAIL gap_length: cs_n high %0d cycles (found=%0d), expected 17", hi, found);
        end
        n_tests++;
        if (bz !== 1) begin
            n_fail++;
            $display("FAIL gap_busy: busy low %0d cycles, expected 1", bz);
        end
        n_tests++;
        if (frame_begin !== 1'b1 || (cyc - first_fb_cyc) !== 2321) begin
            n_fail++;
            $display("FAIL frame_period: fb=%b period %0d, expected 1 2321",
                     frame_begin, cyc - first_fb_cyc);
        end
        cmd_q.delete();
        word_q.delete();
    endtask

    task automatic test_enable_drop();
        bit found = 0;
        int bad = 0, fb = 0, off = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (pixel_index === 13'd10) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL drop_reach: pixel 10 not reached within 2000 cycles");
        end
        enable = 1'b0;
        found = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (cs_n === 1'b1) begin
                found = 1;
                break;
            end
        end
        for (int k = 0; k < word_q.size(); k++)
            if (word_q[k] !== 16'(k)) bad++;
        n_tests++;
        if (!found || word_q.size() !== 32 || bad !== 0) begin
            n_fail++;
            $display("FAIL drop_words: %0d words, %0d wrong (found=%0d), expected 32 0",
                     word_q.size(), bad, found);
        end
        found = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b0) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found || cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_idle: busy low found=%0d cs_n=%b, expected 1 1", found, cs_n);
        end
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (frame_begin !== 1'b0) fb++;
            if (cs_n !== 1'b1 || busy !== 1'b0) off++;
        end
        n_tests++;
        if (fb !== 0 || off !== 0) begin
            n_fail++;
            $display("FAIL drop_stays_idle: %0d frame_begin, %0d active cycles, expected 0 0", fb, off);
        end
    endtask

    task automatic test_reset_mid_pixel();
        bit found = 0;
        int t0, bad = 0;
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_begin === 1'b1) begin
                found = 1;
                break;
            end
        end
        cmd_q.delete();
        word_q.delete();
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (pixel_index === 13'd10 && pix_bits == 9) begin
                found = 1;
                break;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midreset_reach: bit 7 of pixel 10 not reached");
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || pixel_index !== 13'd0 || busy !== 1'b0 || dc !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_async: cs_n=%b sclk=%b idx=%0d busy=%b dc=%b, expected 1 0 0 0 0",
                     cs_n, sclk, pixel_index, busy, dc);
        end
        repeat (3) tick();
        cmd_q.delete();
        word_q.delete();
        rst_n = 1'b1;
        found = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (frame_begin === 1'b1) begin
                found = 1;
                break;
            end
        end
        t0 = cyc;
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL midreset_restart: no frame_begin after release");
        end
        found = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (dc === 1'b1) begin
                found = 1;
                break;
            end
        end
        for (int k = 0; k < 6; k++)
            if (k >= cmd_q.size() || cmd_q[k] !== exp_cmd[k]) bad++;
        n_tests++;
        if (!found || (cyc - t0) !== 192 || cmd_q.size() !== 6 || bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_prelude: %0d cycles, %0d bytes, %0d wrong, expected 192 6 0",
                     cyc - t0, cmd_q.size(), bad);
        end
        enable = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        test_reset();
        test_cmd_prelude();
        test_pixel_data();
        test_frame_timing();
        test_enable_drop();
        test_reset_mid_pixel();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
